// File: rtl/i2c_tx_fifo.sv
// I2C transmit command FIFO: 10-bit {STOP, START, byte} entries, first-word-fall-through,
// with occupancy, threshold level, soft flush and sticky overflow for the status block.
module i2c_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_rst,
  input  logic          wr,
  input  logic [9:0]    din,
  input  logic          rd,
  output logic [9:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   occ,
  input  logic [AW:0]   occ_thresh,
  output logic          thresh_irq,
  output logic          ovf,
  input  logic          ovf_clr
);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_ok, push_ok, overflow, flush;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  assign flush    = rst | fifo_rst;
  assign rd_ok    = rd & ~empty;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign push_ok  = wr & (~full | rd_ok);
  assign overflow = wr & full & ~rd_ok;

  assign empty      = (occ == '0);
  assign full       = (occ == DEPTH_C);
  assign thresh_irq = (occ <= occ_thresh);
  assign dout       = empty ? 10'h000 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)   rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, rd_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset; a discarded push simply never lands.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem[wr_ptr] <= din;
  end

  // Soft flush leaves the sticky flag alone; a new overflow beats a clear.
  always_ff @(posedge clk) begin
    if (rst)                       ovf <= 1'b0;
    else if (!fifo_rst && overflow) ovf <= 1'b1;
    else if (ovf_clr)              ovf <= 1'b0;
  end

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Directed bench for i2c_tx_fifo: a vector table for the basic flow plus hand sequences
// for fill/overflow, full push+pop with wrap, and soft flush vs. hard reset.
module tb_i2c_tx_fifo;

  logic       clk = 1'b0;
  logic       rst, fifo_rst, wr, rd, ovf_clr;
  logic [9:0] din, dout;
  logic       empty, full, thresh_irq, ovf;
  logic [4:0] occ, occ_thresh;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .fifo_rst(fifo_rst), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .empty(empty), .full(full), .occ(occ), .occ_thresh(occ_thresh),
    .thresh_irq(thresh_irq), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic       rst, fr, wr, rd, clr;
    logic [9:0] din;
    logic [4:0] th;
    logic [4:0] e_occ;
    logic [9:0] e_dout;
    logic       e_empty, e_full, e_ovf, e_irq;
  } vec_t;

  vec_t tv [14];

  function automatic vec_t mk(input logic r, input logic f, input logic w, input logic p,
                              input logic c, input logic [9:0] d, input logic [4:0] t,
                              input logic [4:0] eo, input logic [9:0] ed, input logic ee,
                              input logic ef, input logic ev, input logic ei);
    vec_t v;
    v.rst = r; v.fr = f; v.wr = w; v.rd = p; v.clr = c; v.din = d; v.th = t;
    v.e_occ = eo; v.e_dout = ed; v.e_empty = ee; v.e_full = ef; v.e_ovf = ev; v.e_irq = ei;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, then sample 1 time unit later.
  task automatic cyc(input logic r, input logic f, input logic w, input logic p,
                     input logic c, input logic [9:0] d);
    @(negedge clk);
    rst = r; fifo_rst = f; wr = w; rd = p; ovf_clr = c; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int eo, input int ed, input int ee,
                           input int ef, input int ev);
    chk({tag, ".occ"},   int'(occ),   eo);
    chk({tag, ".dout"},  int'(dout),  ed);
    chk({tag, ".empty"}, int'(empty), ee);
    chk({tag, ".full"},  int'(full),  ef);
    chk({tag, ".ovf"},   int'(ovf),   ev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fifo_rst = 1'b0; wr = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
    din = '0; occ_thresh = 5'd2;

    //           rst fr wr rd clr din      th    occ   dout     emp ful ovf irq
    tv[0]  = mk(1, 0, 0, 0, 0, 10'h000, 5'd2, 5'd0, 10'h000, 1, 0, 0, 1);
    tv[1]  = mk(0, 0, 1, 0, 0, 10'h1A0, 5'd2, 5'd1, 10'h1A0, 0, 0, 0, 1);
    tv[2]  = mk(0, 0, 1, 0, 0, 10'h055, 5'd2, 5'd2, 10'h1A0, 0, 0, 0, 1);
    tv[3]  = mk(0, 0, 1, 0, 0, 10'h203, 5'd2, 5'd3, 10'h1A0, 0, 0, 0, 0);
    tv[4]  = mk(0, 0, 0, 1, 0, 10'h000, 5'd2, 5'd2, 10'h055, 0, 0, 0, 1);
    tv[5]  = mk(0, 0, 0, 1, 0, 10'h000, 5'd2, 5'd1, 10'h203, 0, 0, 0, 1);
    tv[6]  = mk(0, 0, 0, 1, 0, 10'h000, 5'd2, 5'd0, 10'h000, 1, 0, 0, 1);
    tv[7]  = mk(0, 0, 0, 1, 0, 10'h000, 5'd2, 5'd0, 10'h000, 1, 0, 0, 1);
    tv[8]  = mk(0, 0, 1, 1, 0, 10'h155, 5'd2, 5'd1, 10'h155, 0, 0, 0, 1);
    tv[9]  = mk(0, 0, 1, 0, 0, 10'h011, 5'd2, 5'd2, 10'h155, 0, 0, 0, 1);
    tv[10] = mk(0, 0, 1, 0, 0, 10'h022, 5'd2, 5'd3, 10'h155, 0, 0, 0, 0);
    tv[11] = mk(0, 0, 1, 0, 0, 10'h033, 5'd2, 5'd4, 10'h155, 0, 0, 0, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 10'h000, 5'd4, 5'd4, 10'h155, 0, 0, 0, 1);
    tv[13] = mk(1, 0, 1, 0, 0, 10'h3C3, 5'd2, 5'd0, 10'h000, 1, 0, 0, 1);

    for (int i = 0; i < 14; i++) begin
      occ_thresh = tv[i].th;
      cyc(tv[i].rst, tv[i].fr, tv[i].wr, tv[i].rd, tv[i].clr, tv[i].din);
      chk_state($sformatf("vec%0d", i), tv[i].e_occ, tv[i].e_dout, tv[i].e_empty,
                tv[i].e_full, tv[i].e_ovf);
      chk($sformatf("vec%0d.irq", i), int'(thresh_irq), int'(tv[i].e_irq));
    end

    // Fill to full, then overflow and clear
    occ_thresh = 5'd2;
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0, 10'(i));
    chk_state("fill", 16, 'h000, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 10'h3FF);
    chk_state("ovf_push", 16, 'h000, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 10'h000);
    chk_state("ovf_clr", 16, 'h000, 0, 1, 0);

    // Full with simultaneous push and pop, then drain across the pointer wrap
    cyc(0, 0, 1, 1, 0, 10'h2AA);
    chk_state("full_wr_rd", 16, 'h001, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.dout", i), int'(dout), (i < 15) ? i + 1 : 'h2AA);
      cyc(0, 0, 0, 1, 0, 10'h000);
      chk($sformatf("drain%0d.occ", i), int'(occ), 15 - i);
    end
    chk_state("drained", 0, 'h000, 1, 0, 0);

    // Build ovf=1 with 5 entries left, then flush with a concurrent push
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0, 10'h100 + 10'(i));
    cyc(0, 0, 1, 0, 0, 10'h3FF);
    chk("pre_flush.ovf", int'(ovf), 1);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 1, 0, 10'h000);
    chk_state("five_left", 5, 'h10B, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 10'h0F0);
    chk_state("flush", 0, 'h000, 1, 0, 1);
    cyc(0, 0, 1, 0, 0, 10'h123);
    chk_state("post_flush_push", 1, 'h123, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 10'h000);
    chk_state("hard_rst", 0, 'h000, 1, 0, 0);
    chk("hard_rst.irq", int'(thresh_irq), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_tx_fifo.md
Name: i2c_tx_fifo

Overview:
- Transmit command FIFO between the register/bus interface and the I2C dynamic-control and byte-engine stages.
- Each 10-bit entry is one command word:
  - bit9 = STOP after this byte
  - bit8 = START (repeated START if the bus is already owned)
  - bits7:0 = address or data byte; for a START entry with bit0=1 (read), the next entry carries the receive byte count.
- First-word-fall-through: the head entry is visible on dout while non-empty, so downstream logic can decode START/STOP before popping.
- Provides occupancy, threshold, soft flush and overflow reporting for the status and interrupt registers.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2.
- AW, 4, log2(DEPTH); pointer width. Occupancy width is AW+1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- fifo_rst  input  1  soft flush from the control register (TX_FIFO reset bit); synchronous, level-sensitive.
- wr  input  1  push strobe, one entry per cycle.
- din  input  10  entry to push.
- rd  input  1  pop strobe from the downstream consumer.
- dout  output  10  head entry (FWFT).
- empty  output  1  no entries.
- full  output  1  DEPTH entries.
- occ  output  AW+1  current entry count, 0..DEPTH.
- occ_thresh  input  AW+1  threshold from the register block.
- thresh_irq  output  1  level: occ <= occ_thresh.
- ovf  output  1  sticky: push attempted while full.
- ovf_clr  input  1  clears ovf (write-1-to-clear pulse).

Behaviour:
- Reset and flush:
  - Reset is synchronous: rst=1 at a rising edge sets wr_ptr=0, rd_ptr=0, occ=0, empty=1, full=0, ovf=0.
  - thresh_irq is then (0 <= occ_thresh), i.e. 1.
  - Memory contents are not reset.
  - fifo_rst has the same effect as rst on pointers, occ, empty and full, but leaves ovf unchanged.
  - rst or fifo_rst overrides any wr/rd in the same cycle; that push or pop is discarded.
  - A reset arriving mid-transfer simply discards all entries.
- Storage:
  - Circular buffer mem[DEPTH] of 10 bits.
  - Pointers are AW bits and wrap DEPTH-1 -> 0 naturally.
  - occ is held in a separate AW+1-bit counter.
- Push accepted (push_ok) when wr=1 and (full=0 or rd_ok=1): mem[wr_ptr] <= din, wr_ptr <= wr_ptr+1.
- Pop accepted (rd_ok) when rd=1 and empty=0: rd_ptr <= rd_ptr+1.
- Counter update:
  - occ +1 on push only.
  - occ -1 on pop only.
  - occ unchanged on push and pop in the same cycle, including when full.
- Empty FIFO with wr=1 and rd=1 in the same cycle:
  - The pop is ignored (underflow, no state change).
  - The push is accepted; occ becomes 1.
- Full FIFO with wr=1 and rd=0:
  - The push is dropped; pointers and occ are unchanged.
  - ovf <= 1 on the next edge.
- ovf update:
  - ovf_clr=1 clears ovf.
  - If ovf_clr and a new overflow occur in the same cycle, set wins (ovf=1).
- Flags and outputs:
  - empty = (occ==0); full = (occ==DEPTH); both registered-equivalent, derived from the occ register.
  - dout = mem[rd_ptr] when empty=0, else 10'h000 (deterministic).
  - Latency: an entry written at edge N appears on dout with empty=0 after edge N; 1-cycle write-to-read.
  - After a pop at edge N, dout shows the next entry after edge N, with no bubble.
  - thresh_irq is combinational from occ and occ_thresh, with no extra latency.
- No read-during-write hazard: a write never targets rd_ptr while empty=0, except the full+pop case, where the write lands at the slot being vacated.
- Bus-side software writes into wr/din are single-cycle pulses; the block does not require wr to deassert between pushes.

Test Plan:
- Reset, then push 0x1A0, 0x055, 0x203 on consecutive cycles -> after each edge occ=1,2,3; dout=0x1A0 one cycle after the first push; empty=0.
- Pop three times back-to-back -> dout sequence 0x1A0, 0x055, 0x203; then empty=1, dout=0x000, occ=0; a fourth rd is ignored with occ still 0.
- Fill 16 entries (0x000..0x00F), then push 0x3FF with rd=0 -> full=1, ovf=1, occ=16, entry dropped; then pulse ovf_clr -> ovf=0.
- Full FIFO with rd=1 and wr=1 (din=0x2AA) in one cycle -> occ stays 16, head advances to 0x001; after 16 more pops the last entry popped is 0x2AA; the pointer wrap is exercised.
- occ_thresh=2 with occ stepping 0..4 -> thresh_irq=1 for occ 0..2 and 0 for occ 3..4; empty FIFO with wr=1 and rd=1 simultaneously -> occ=1, dout=din.
- With 5 entries and ovf=1, assert fifo_rst together with wr=1 -> occ=0, empty=1, ovf remains 1, the pushed entry is discarded; a later rst -> ovf=0.
